// File: rtl/stack_ctrl.sv
// Hardware stack data side: push/pop command/response handshake over local storage.
// Optional macro STACK_PEEK_EN enables non-destructive pop (peek) via cmd_peek.
module stack_ctrl #(
    parameter int unsigned BITS       = 8,
    parameter int unsigned DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [BITS-1:0]       cmd_data,
    input  logic                  cmd_peek,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITS-1:0]       rsp_data,
    output logic                  rsp_err,
    output logic [DEPTH_BITS:0]   sp,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam int unsigned SPW   = DEPTH_BITS + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_nx;
    logic                  op_q;
    logic [BITS-1:0]       data_q;
    logic                  peek_eff;
    logic [SPW-1:0]        sp_nx;
    logic                  err_nx;
    logic                  mem_we;
    logic                  rd_en;
    logic [BITS-1:0]       mem [DEPTH];
    logic [DEPTH_BITS-1:0] wr_idx;
    logic [DEPTH_BITS-1:0] top_idx;

    assign wr_idx  = sp[DEPTH_BITS-1:0];
    assign top_idx = DEPTH_BITS'(sp - SPW'(1));

`ifdef STACK_PEEK_EN
    logic peek_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            peek_q <= 1'b0;
        end else if (state == IDLE && cmd_valid) begin
            peek_q <= cmd_peek;
        end
    end

    assign peek_eff = peek_q;
`else
    logic unused_peek;

    assign unused_peek = cmd_peek;
    assign peek_eff    = 1'b0;
`endif

    // Next-state and EXEC-cycle decisions; erroring commands leave sp and storage alone.
    always_comb begin
        state_nx = state;
        sp_nx    = sp;
        err_nx   = rsp_err;
        mem_we   = 1'b0;
        rd_en    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                state_nx = RESP;
                err_nx   = 1'b0;
                if (op_q) begin
                    if (full) begin
                        err_nx = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        sp_nx  = sp + SPW'(1);
                    end
                end else if (empty) begin
                    err_nx = 1'b1;
                end else begin
                    rd_en = 1'b1;
                    if (!peek_eff) begin
                        sp_nx = sp - SPW'(1);
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sp        <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            empty     <= 1'b1;
            full      <= 1'b0;
            op_q      <= 1'b0;
            data_q    <= '0;
        end else begin
            state     <= state_nx;
            sp        <= sp_nx;
            rsp_err   <= err_nx;
            cmd_ready <= (state_nx == IDLE);
            rsp_valid <= (state_nx == RESP);
            full      <= (sp_nx == SPW'(DEPTH));
            empty     <= (sp_nx == SPW'(0));
            if (state == IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end
            // Synchronous read of the top entry; pushes and errors report zero.
            if (rd_en) begin
                rsp_data <= mem[top_idx];
            end else if (state == EXEC) begin
                rsp_data <= '0;
            end
        end
    end

    // Storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_idx] <= data_q;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: directed table, hand sequences and a queue-based random model.
module tb_stack_ctrl;

    localparam int unsigned BITS       = 8;
    localparam int unsigned DEPTH_BITS = 4;
    localparam int unsigned DEPTH      = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_op = 1'b0;
    logic [BITS-1:0]   cmd_data = '0;
    logic              cmd_peek = 1'b0;
    logic              rsp_ready = 1'b0;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [BITS-1:0]   rsp_data;
    logic              rsp_err;
    logic [DEPTH_BITS:0] sp;
    logic              full;
    logic              empty;

    int total  = 0;
    int passed = 0;
    logic [7:0] model[$];

    typedef struct {
        logic       op;
        logic [7:0] data;
        logic       peek;
        logic [7:0] exp_data;
        logic       exp_err;
        logic [4:0] exp_sp;
    } vec_t;

    vec_t vecs[7];

    stack_ctrl #(.BITS(BITS), .DEPTH_BITS(DEPTH_BITS)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_peek(cmd_peek),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .sp(sp), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model.delete();
    endtask

    // One full command/response transaction with handshake-timing checks.
    task automatic issue(input logic op, input logic [7:0] d, input logic pk,
                         output logic [7:0] rd, output logic er);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        if (cmd_ready !== 1'b1) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_peek = pk;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("exec_cmd_ready_low", 32'(cmd_ready), 32'd0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("rsp_latency", 32'(n), 32'd1);
        rd = rsp_data;
        er = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    // Transaction checked against a LIFO queue model.
    task automatic run(input logic op, input logic [7:0] d, input logic pk,
                       output logic [7:0] rd, output logic er);
        logic [7:0] erd;
        logic       eer;
        logic       peek_mode;
        peek_mode = pk;
`ifndef STACK_PEEK_EN
        peek_mode = 1'b0;
`endif
        issue(op, d, pk, rd, er);
        erd = 8'h00;
        eer = 1'b0;
        if (op) begin
            if (model.size() < DEPTH) model.push_back(d);
            else eer = 1'b1;
        end else if (model.size() == 0) begin
            eer = 1'b1;
        end else begin
            erd = model[$];
            if (!peek_mode) void'(model.pop_back());
        end
        check("model_rsp_data", 32'(rd), 32'(erd));
        check("model_rsp_err", 32'(er), 32'(eer));
        check("model_sp", 32'(sp), 32'(model.size()));
        check("model_full", 32'(full), 32'(model.size() == DEPTH));
        check("model_empty", 32'(empty), 32'(model.size() == 0));
    endtask

    initial begin
        logic [7:0] rd;
        logic       er;
        int         cyc;

        vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 5'd0};
        vecs[1] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 5'd1};
        vecs[2] = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 5'd2};
        vecs[3] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 5'd3};
        vecs[4] = '{1'b0, 8'hFF, 1'b0, 8'h33, 1'b0, 5'd2};
        vecs[5] = '{1'b0, 8'hFF, 1'b0, 8'h22, 1'b0, 5'd1};
        vecs[6] = '{1'b0, 8'hFF, 1'b0, 8'h11, 1'b0, 5'd0};

        do_reset();
        check("rst_sp", 32'(sp), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);

        foreach (vecs[i]) begin
            run(vecs[i].op, vecs[i].data, vecs[i].peek, rd, er);
            check($sformatf("vec%0d_data", i), 32'(rd), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_sp", i), 32'(sp), 32'(vecs[i].exp_sp));
        end
        check("vec_end_empty", 32'(empty), 32'd1);

        // Fill to capacity, overflow, then pop the top.
        do_reset();
        for (int i = 0; i < 16; i++) run(1'b1, 8'(i), 1'b0, rd, er);
        check("fill_full", 32'(full), 32'd1);
        check("fill_sp", 32'(sp), 32'd16);
        run(1'b1, 8'hAA, 1'b0, rd, er);
        check("overflow_err", 32'(er), 32'd1);
        check("overflow_sp", 32'(sp), 32'd16);
        run(1'b0, 8'h00, 1'b0, rd, er);
        check("after_full_pop", 32'(rd), 32'h0F);
        check("after_full_err", 32'(er), 32'd0);

        // Response stall: outputs must hold while rsp_ready is low.
        do_reset();
        run(1'b1, 8'h5C, 1'b0, rd, er);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 8'h00; cmd_peek = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        void'(model.pop_back());
        for (int i = 0; i < 5; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_data", 32'(rsp_data), 32'h5C);
            check("stall_rsp_err", 32'(rsp_err), 32'd0);
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_sp", 32'(sp), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("stall_release_valid", 32'(rsp_valid), 32'd0);
        check("stall_release_ready", 32'(cmd_ready), 32'd1);

        // Reset while a push is in EXEC drops the command.
        run(1'b1, 8'h44, 1'b0, rd, er);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_data = 8'h99; cmd_peek = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model.delete();
        check("exec_rst_sp", 32'(sp), 32'd0);
        check("exec_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("exec_rst_empty", 32'(empty), 32'd1);
        run(1'b0, 8'h00, 1'b0, rd, er);
        check("exec_rst_pop_err", 32'(er), 32'd1);

        // Peek sequence.
        do_reset();
        run(1'b1, 8'h7E, 1'b0, rd, er);
        run(1'b0, 8'h00, 1'b1, rd, er);
        check("peek1_data", 32'(rd), 32'h7E);
        run(1'b0, 8'h00, 1'b1, rd, er);
`ifdef STACK_PEEK_EN
        check("peek2_data", 32'(rd), 32'h7E);
        check("peek2_err", 32'(er), 32'd0);
        check("peek2_sp", 32'(sp), 32'd1);
`else
        check("peek2_data", 32'(rd), 32'h00);
        check("peek2_err", 32'(er), 32'd1);
        check("peek2_sp", 32'(sp), 32'd0);
`endif
        run(1'b0, 8'h00, 1'b0, rd, er);

        // Randomized: push-biased phase then pop-biased phase.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic rop;
            if (i < 150) rop = ($urandom_range(0, 3) != 0);
            else rop = ($urandom_range(0, 3) == 0);
            run(rop, 8'($urandom), ($urandom_range(0, 3) == 0), rd, er);
        end

        cyc = 0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
